iq_bank: RTL and testbench
==========================

IQ_BANK -- requirements
Module: iq_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two, 2..32).
REQ-002 SHALL have parameter REG_COUNT, default 2, source operands per entry.
REQ-003 SHALL have parameter CDB_COUNT, default 2, CDB broadcast channels.
REQ-004 SHALL have parameter WKUP_COUNT, default 2, speculative wakeup channels.
REQ-005 SHALL have parameters DATA_W (default 32, operand width), TAG_W (default 6, producer tag width) and PAYLOAD_W (default 64, opaque control payload width).
REQ-006 SHALL have port clk, input, 1, clock; reset rst_n, synchronous, active-low.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port flush, input, 1, discard all entries.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), insert handshake.
REQ-010 SHALL have ports in_data [REG_COUNT][DATA_W], in_tag [REG_COUNT][TAG_W] and in_rdy [REG_COUNT] (all inputs): operand value, producer tag, operand already valid.
REQ-011 SHALL have port in_payload, input, PAYLOAD_W, stored unchanged.
REQ-012 SHALL have inputs wkup_valid [WKUP_COUNT], wkup_tag [WKUP_COUNT][TAG_W] and wkup_data [WKUP_COUNT][DATA_W]; wkup_data is the value for the tag announced two cycles earlier.
REQ-013 SHALL have inputs cdb_valid [CDB_COUNT], cdb_tag [CDB_COUNT][TAG_W] and cdb_data [CDB_COUNT][DATA_W].
REQ-014 SHALL have ports out_valid (output, 1) and out_ready (input, 1), issue handshake.
REQ-015 SHALL have outputs out_data [REG_COUNT][DATA_W] and out_payload (PAYLOAD_W), the selected entry.
REQ-016 SHALL have output count_o, clog2(DEPTH)+1 bits, occupied entries.

Function
REQ-017 SHALL assert in_ready combinationally iff count_o < DEPTH; no same-cycle issue-to-insert bypass.
REQ-018 SHALL, on insert, write the lowest-index free entry, valid from the next cycle.
REQ-019 SHALL, for an inserted operand with in_rdy=0 whose tag matches a valid CDB channel in the insert cycle, store the CDB value and mark the operand ready.
REQ-020 SHALL, on a valid CDB tag match against a stored non-ready operand, capture the data and set the operand ready at the next edge; the lowest channel index wins on duplicate matches.
REQ-021 SHALL, on a valid wakeup tag match at cycle t against a non-ready operand, set a pending flag and shift it through a 2-stage pipeline, reaching stage 2 at cycle t+2.
REQ-022 SHALL treat an operand in stage 2 as ready at t+2, drive out_data from wkup_data of the matching channel, and latch that value at the t+2 edge.
REQ-023 SHALL, when CDB and stage-2 wakeup hit the same operand in the same cycle, take the CDB value.
REQ-024 SHALL deem an entry eligible when valid and every operand is ready or in stage 2.
REQ-025 SHALL drive out_valid combinationally iff any entry is eligible; out_data/out_payload reflect the selected entry.
REQ-026 SHALL free the selected entry on out_valid && out_ready, clearing its pending wakeup stages.
REQ-027 SHALL hold count_o unchanged on simultaneous insert and issue; it SHALL be incremented by insert-only and decremented by issue-only.

Reset
REQ-028 SHALL, on rst_n=0 or flush=1 at an edge, clear all valid bits, ready flags and wakeup stages; count_o=0.
REQ-029 SHALL give flush priority over same-cycle insert and issue; the insert is dropped and the issue is not counted.
REQ-030 SHALL after reset present out_valid=0, in_ready=1, out_data=0, out_payload=0.

Configuration
REQ-031 SHALL, with IQ_AGE_SELECT_EN defined, keep a DEPTH x DEPTH age matrix updated on insert/free and select the oldest eligible entry.
REQ-032 SHALL, without IQ_AGE_SELECT_EN, omit the age matrix and select the lowest-index eligible entry.

Verification
REQ-033 SHALL cover: 8 inserts with in_rdy=11, out_ready=0 -> count_o=8, in_ready=0; one issue -> count_o=7, in_ready=1.
REQ-034 SHALL cover: insert with tag0=5, rdy=01; wkup tag 5 at t, wkup_data=0xCAFE at t+2 -> out_valid=1 at t+2, out_data[0]=0xCAFE.
REQ-035 SHALL cover: stored operand with tag 9; CDB tag 9, data 0x1234 at t -> out_valid at t+1, out_data[0]=0x1234; CDB tag 9 on insert cycle -> same value captured.
REQ-036 SHALL cover: with IQ_AGE_SELECT_EN, entries A (idx 3) then B (idx 1) both ready -> A issues first; without the macro -> B issues first.
REQ-037 SHALL cover: flush with wkup pending at stage 1 and simultaneous insert -> count_o=0, out_valid=0 in the next two cycles.

Source files
------------

// File: rtl/iq_bank.sv
`default_nettype none
// ============================================================================
// Module      : iq_bank
// Description : Issue-queue bank. Holds DEPTH entries of REG_COUNT source
//               operands plus an opaque payload. Operands become ready from
//               CDB broadcasts (captured at the next edge) or from speculative
//               wakeups whose data arrives two cycles after the tag. One
//               eligible entry is presented on the issue port each cycle.
//               Build macro IQ_AGE_SELECT_EN: oldest-eligible selection through
//               an age matrix; when undefined the lowest-index eligible entry
//               is selected.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_bank #(
    parameter int DEPTH      = 8,
    parameter int REG_COUNT  = 2,
    parameter int CDB_COUNT  = 2,
    parameter int WKUP_COUNT = 2,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [REG_COUNT-1:0][DATA_W-1:0]      in_data,
    input  logic [REG_COUNT-1:0][TAG_W-1:0]       in_tag,
    input  logic [REG_COUNT-1:0]                  in_rdy,
    input  logic [PAYLOAD_W-1:0]                  in_payload,
    input  logic [WKUP_COUNT-1:0]                 wkup_valid,
    input  logic [WKUP_COUNT-1:0][TAG_W-1:0]      wkup_tag,
    input  logic [WKUP_COUNT-1:0][DATA_W-1:0]     wkup_data,
    input  logic [CDB_COUNT-1:0]                  cdb_valid,
    input  logic [CDB_COUNT-1:0][TAG_W-1:0]       cdb_tag,
    input  logic [CDB_COUNT-1:0][DATA_W-1:0]      cdb_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [REG_COUNT-1:0][DATA_W-1:0]      out_data,
    output logic [PAYLOAD_W-1:0]                  out_payload,
    output logic [$clog2(DEPTH):0]                count_o
);

    localparam int                 c_IDX_W     = $clog2(DEPTH);
    localparam int                 c_WK_W      = (WKUP_COUNT > 1) ? $clog2(WKUP_COUNT) : 1;
    localparam logic [c_IDX_W:0]   c_DEPTH_CNT = (c_IDX_W + 1)'(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]        r_valid;
    logic [PAYLOAD_W-1:0]    r_payload [DEPTH];
    logic [DATA_W-1:0]       r_data    [DEPTH][REG_COUNT];
    logic [TAG_W-1:0]        r_tag     [DEPTH][REG_COUNT];
    logic [REG_COUNT-1:0]    r_rdy     [DEPTH];
    logic [REG_COUNT-1:0]    r_s1      [DEPTH];
    logic [REG_COUNT-1:0]    r_s2      [DEPTH];
    logic [c_WK_W-1:0]       r_s1_ch   [DEPTH][REG_COUNT];
    logic [c_WK_W-1:0]       r_s2_ch   [DEPTH][REG_COUNT];
    logic [c_IDX_W:0]        r_count;

    // Per-operand match results and resolved values
    logic [REG_COUNT-1:0]    w_cdb_hit  [DEPTH];
    logic [DATA_W-1:0]       w_cdb_val  [DEPTH][REG_COUNT];
    logic [REG_COUNT-1:0]    w_wk_hit   [DEPTH];
    logic [c_WK_W-1:0]       w_wk_ch    [DEPTH][REG_COUNT];
    logic [DATA_W-1:0]       w_s2_val   [DEPTH][REG_COUNT];
    logic [DATA_W-1:0]       w_opnd_val [DEPTH][REG_COUNT];
    logic [DEPTH-1:0]        w_elig;

    logic [REG_COUNT-1:0]    w_in_cdb_hit;
    logic [DATA_W-1:0]       w_in_cdb_val [REG_COUNT];

    logic                    w_ins;
    logic                    w_issue;
    logic                    w_any;
    logic [c_IDX_W-1:0]      w_ins_idx;
    logic [c_IDX_W-1:0]      w_sel;

    assign in_ready = (r_count < c_DEPTH_CNT);
    assign count_o  = r_count;
    assign w_ins    = in_valid && in_ready && !flush;
    assign w_issue  = w_any && out_ready && !flush;

    // Tag matching against CDB / wakeup channels; lowest channel index wins.
    // An operand sitting in wakeup stage 2 counts as ready this cycle.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_elig[e]   = r_valid[e];
            w_cdb_hit[e] = '0;
            w_wk_hit[e]  = '0;
            for (int r = 0; r < REG_COUNT; r++) begin
                w_cdb_val[e][r] = '0;
                for (int c = CDB_COUNT - 1; c >= 0; c--) begin
                    if (cdb_valid[c] && (cdb_tag[c] == r_tag[e][r])) begin
                        w_cdb_hit[e][r] = 1'b1;
                        w_cdb_val[e][r] = cdb_data[c];
                    end
                end
                w_wk_ch[e][r] = '0;
                for (int w = WKUP_COUNT - 1; w >= 0; w--) begin
                    if (wkup_valid[w] && (wkup_tag[w] == r_tag[e][r])) begin
                        w_wk_hit[e][r] = 1'b1;
                        w_wk_ch[e][r]  = c_WK_W'(w);
                    end
                end
                w_s2_val[e][r] = '0;
                for (int w = 0; w < WKUP_COUNT; w++) begin
                    if (r_s2_ch[e][r] == c_WK_W'(w)) begin
                        w_s2_val[e][r] = wkup_data[w];
                    end
                end
                if (r_rdy[e][r]) begin
                    w_opnd_val[e][r] = r_data[e][r];
                end else if (w_cdb_hit[e][r]) begin
                    w_opnd_val[e][r] = w_cdb_val[e][r];
                end else begin
                    w_opnd_val[e][r] = w_s2_val[e][r];
                end
                if (!(r_rdy[e][r] || r_s2[e][r])) begin
                    w_elig[e] = 1'b0;
                end
            end
        end
    end

    // CDB capture for operands arriving on the insert port
    always_comb begin
        w_in_cdb_hit = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            w_in_cdb_val[r] = '0;
            for (int c = CDB_COUNT - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_tag[c] == in_tag[r])) begin
                    w_in_cdb_hit[r] = 1'b1;
                    w_in_cdb_val[r] = cdb_data[c];
                end
            end
        end
    end

    // Lowest-index free slot receives the next insert
    always_comb begin
        w_ins_idx = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!r_valid[e]) begin
                w_ins_idx = c_IDX_W'(e);
            end
        end
    end

`ifdef IQ_AGE_SELECT_EN
    // r_age[i][j] set means entry i was inserted before entry j
    logic [DEPTH-1:0] r_age [DEPTH];

    // Age matrix: a new entry is younger than every other slot
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_age[w_sel] <= '0;
            end
            if (w_ins) begin
                for (int j = 0; j < DEPTH; j++) begin
                    r_age[j][w_ins_idx] <= (j != int'(w_ins_idx));
                    r_age[w_ins_idx][j] <= 1'b0;
                end
            end
        end
    end

    // Oldest eligible: no other eligible entry is older than it
    always_comb begin
        logic w_blk;
        w_any = |w_elig;
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (w_elig[j] && r_age[j][i]) begin
                    w_blk = 1'b1;
                end
            end
            if (w_elig[i] && !w_blk) begin
                w_sel = c_IDX_W'(i);
            end
        end
    end
`else
    // Lowest-index eligible entry is selected
    always_comb begin
        w_any = |w_elig;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel = c_IDX_W'(i);
            end
        end
    end
`endif

    // Issue port shows the selected entry, zero when nothing is eligible
    always_comb begin
        out_valid   = w_any;
        out_payload = w_any ? r_payload[w_sel] : '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            out_data[r] = w_any ? w_opnd_val[w_sel][r] : '0;
        end
    end

    // Entry state: free on issue, fill on insert, otherwise track operand readiness
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count <= '0;
            r_valid <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_rdy[e] <= '0;
                r_s1[e]  <= '0;
                r_s2[e]  <= '0;
            end
        end else begin
            if (w_ins && !w_issue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_ins && w_issue) begin
                r_count <= r_count - 1'b1;
            end
            for (int e = 0; e < DEPTH; e++) begin
                if (w_issue && (int'(w_sel) == e)) begin
                    r_valid[e] <= 1'b0;
                    r_s1[e]    <= '0;
                    r_s2[e]    <= '0;
                end else if (w_ins && (int'(w_ins_idx) == e)) begin
                    r_valid[e]   <= 1'b1;
                    r_payload[e] <= in_payload;
                    r_s1[e]      <= '0;
                    r_s2[e]      <= '0;
                    for (int r = 0; r < REG_COUNT; r++) begin
                        r_tag[e][r] <= in_tag[r];
                        if (in_rdy[r]) begin
                            r_data[e][r] <= in_data[r];
                            r_rdy[e][r]  <= 1'b1;
                        end else if (w_in_cdb_hit[r]) begin
                            r_data[e][r] <= w_in_cdb_val[r];
                            r_rdy[e][r]  <= 1'b1;
                        end else begin
                            r_rdy[e][r]  <= 1'b0;
                        end
                    end
                end else if (r_valid[e]) begin
                    for (int r = 0; r < REG_COUNT; r++) begin
                        if (!r_rdy[e][r]) begin
                            if (w_cdb_hit[e][r]) begin
                                // CDB outranks a wakeup landing in the same cycle
                                r_data[e][r] <= w_cdb_val[e][r];
                                r_rdy[e][r]  <= 1'b1;
                                r_s1[e][r]   <= 1'b0;
                                r_s2[e][r]   <= 1'b0;
                            end else if (r_s2[e][r]) begin
                                r_data[e][r] <= w_s2_val[e][r];
                                r_rdy[e][r]  <= 1'b1;
                                r_s1[e][r]   <= 1'b0;
                                r_s2[e][r]   <= 1'b0;
                            end else begin
                                r_s2[e][r]      <= r_s1[e][r];
                                r_s2_ch[e][r]   <= r_s1_ch[e][r];
                                r_s1[e][r]      <= w_wk_hit[e][r];
                                r_s1_ch[e][r]   <= w_wk_ch[e][r];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iq_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_bank
// Description : Self-checking bench for iq_bank: vector table for occupancy,
//               directed wakeup/CDB/selection/flush sequences, then random
//               traffic against a cycle-numbered reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_bank;

    localparam int DEPTH = 8;
    localparam int RC    = 2;
    localparam int CC    = 2;
    localparam int WC    = 2;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int PW    = 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [RC-1:0][DW-1:0]     in_data;
    logic [RC-1:0][TW-1:0]     in_tag;
    logic [RC-1:0]             in_rdy;
    logic [PW-1:0]             in_payload;
    logic [WC-1:0]             wkup_valid;
    logic [WC-1:0][TW-1:0]     wkup_tag;
    logic [WC-1:0][DW-1:0]     wkup_data;
    logic [CC-1:0]             cdb_valid;
    logic [CC-1:0][TW-1:0]     cdb_tag;
    logic [CC-1:0][DW-1:0]     cdb_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [RC-1:0][DW-1:0]     out_data;
    logic [PW-1:0]             out_payload;
    logic [$clog2(DEPTH):0]    count_o;

    always #5 clk = ~clk;

    iq_bank #(
        .DEPTH(DEPTH), .REG_COUNT(RC), .CDB_COUNT(CC), .WKUP_COUNT(WC),
        .DATA_W(DW), .TAG_W(TW), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .in_rdy(in_rdy), .in_payload(in_payload),
        .wkup_valid(wkup_valid), .wkup_tag(wkup_tag), .wkup_data(wkup_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_payload(out_payload), .count_o(count_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; in_rdy = '0;
        in_payload = '0; wkup_valid = '0; wkup_tag = '0; wkup_data = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b0;
    endtask

    // Move to the next cycle: inputs change 1 time unit after the edge
    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ins(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                       input logic [RC-1:0] rdy, input logic [PW-1:0] pl);
        in_valid = 1'b1;
        in_data[0] = d0; in_data[1] = d1;
        in_tag[0] = t0;  in_tag[1] = t1;
        in_rdy = rdy;    in_payload = pl;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Each operand is ready, or has a due cycle at which its wakeup data lands.
    bit          m_v   [DEPTH];
    logic [PW-1:0] m_pl [DEPTH];
    int          m_seq [DEPTH];
    bit          m_rdy [DEPTH][RC];
    logic [DW-1:0] m_val [DEPTH][RC];
    logic [TW-1:0] m_tag [DEPTH][RC];
    int          m_due [DEPTH][RC];
    int          m_ch  [DEPTH][RC];
    int          cyc;
    int          seq_ctr;

    int            e_cnt;
    bit            e_ov;
    int            e_sel;
    logic [DW-1:0] e_data [RC];
    logic [PW-1:0] e_pl;

    function automatic bit cdb_find(input logic [TW-1:0] tag, output logic [DW-1:0] val);
        val = '0;
        for (int c = 0; c < CC; c++) begin
            if (cdb_valid[c] && cdb_tag[c] == tag) begin
                val = cdb_data[c];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int wk_find(input logic [TW-1:0] tag);
        for (int w = 0; w < WC; w++) begin
            if (wkup_valid[w] && wkup_tag[w] == tag) return w;
        end
        return -1;
    endfunction

    task automatic m_clear();
        for (int e = 0; e < DEPTH; e++) m_v[e] = 1'b0;
    endtask

    task automatic m_eval();
        logic [DW-1:0] cv;
        bit ok;
        e_cnt = 0; e_ov = 1'b0; e_sel = -1; e_pl = '0;
        for (int r = 0; r < RC; r++) e_data[r] = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!m_v[e]) continue;
            e_cnt++;
            ok = 1'b1;
            for (int r = 0; r < RC; r++)
                if (!m_rdy[e][r] && m_due[e][r] != cyc) ok = 1'b0;
            if (!ok) continue;
`ifdef IQ_AGE_SELECT_EN
            if (e_sel < 0 || m_seq[e] < m_seq[e_sel]) e_sel = e;
`else
            if (e_sel < 0) e_sel = e;
`endif
        end
        if (e_sel >= 0) begin
            e_ov = 1'b1;
            e_pl = m_pl[e_sel];
            for (int r = 0; r < RC; r++) begin
                if (m_rdy[e_sel][r]) e_data[r] = m_val[e_sel][r];
                else if (cdb_find(m_tag[e_sel][r], cv)) e_data[r] = cv;
                else e_data[r] = wkup_data[m_ch[e_sel][r]];
            end
        end
    endtask

    task automatic m_step();
        logic [DW-1:0] cv;
        int k;
        int ch;
        bit iss;
        if (!rst_n || flush) begin
            m_clear();
        end else begin
            iss = e_ov && out_ready;
            k = -1;
            if (in_valid && e_cnt < DEPTH) begin
                for (int e = DEPTH - 1; e >= 0; e--) if (!m_v[e]) k = e;
            end
            for (int e = 0; e < DEPTH; e++) begin
                if (!m_v[e] || (iss && e == e_sel)) continue;
                for (int r = 0; r < RC; r++) begin
                    if (m_rdy[e][r]) continue;
                    if (cdb_find(m_tag[e][r], cv)) begin
                        m_rdy[e][r] = 1'b1; m_val[e][r] = cv;
                    end else if (m_due[e][r] == cyc) begin
                        m_rdy[e][r] = 1'b1; m_val[e][r] = wkup_data[m_ch[e][r]];
                    end else if (m_due[e][r] < 0) begin
                        ch = wk_find(m_tag[e][r]);
                        if (ch >= 0) begin
                            m_due[e][r] = cyc + 2; m_ch[e][r] = ch;
                        end
                    end
                end
            end
            if (iss) m_v[e_sel] = 1'b0;
            if (k >= 0) begin
                m_v[k] = 1'b1; m_pl[k] = in_payload; m_seq[k] = seq_ctr++;
                for (int r = 0; r < RC; r++) begin
                    m_tag[k][r] = in_tag[r];
                    m_due[k][r] = -1;
                    if (in_rdy[r]) begin
                        m_rdy[k][r] = 1'b1; m_val[k][r] = in_data[r];
                    end else if (cdb_find(in_tag[r], cv)) begin
                        m_rdy[k][r] = 1'b1; m_val[k][r] = cv;
                    end else begin
                        m_rdy[k][r] = 1'b0;
                    end
                end
            end
        end
        cyc++;
    endtask

    // ---------------- occupancy vector table ----------------
    typedef struct {
        logic       iv;
        logic       ordy;
        logic [3:0] cnt;
        logic       ir;
        logic       ov;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [PW-1:0] exp_first;
        logic [PW-1:0] exp_second;

        vt[0] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
        for (int i = 1; i < 8; i++) vt[i] = '{1'b1, 1'b0, 4'(i), 1'b1, 1'b1};
        vt[8]  = '{1'b1, 1'b0, 4'd8, 1'b0, 1'b1};   // insert attempt while full
        vt[9]  = '{1'b0, 1'b1, 4'd8, 1'b0, 1'b1};   // issue
        vt[10] = '{1'b0, 1'b0, 4'd7, 1'b1, 1'b1};
        vt[11] = '{1'b1, 1'b1, 4'd7, 1'b1, 1'b1};   // insert + issue together
        vt[12] = '{1'b0, 1'b0, 4'd7, 1'b1, 1'b1};

        do_reset();
        smp();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_count", count_o, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_payload", out_payload, 0);

        for (int i = 0; i < 13; i++) begin
            nxt();
            in_valid = vt[i].iv;
            out_ready = vt[i].ordy;
            in_rdy = 2'b11;
            in_data[0] = DW'(i); in_data[1] = DW'(i + 100);
            in_payload = PW'(i);
            smp();
            chk($sformatf("vec%0d_count", i), count_o, vt[i].cnt);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ov);
        end
        nxt(); flush = 1'b1;
        nxt(); smp();
        chk("flush_count", count_o, 0);
        chk("flush_out_valid", out_valid, 0);

        // speculative wakeup: tag at t, data at t+2
        nxt(); ins(32'h11, 32'h22, 6'd5, 6'd7, 2'b10, 64'h34); smp();
        nxt(); wkup_valid = 2'b10; wkup_tag[1] = 6'd5; smp();
        chk("wk_t_out_valid", out_valid, 0);
        nxt(); smp();
        chk("wk_t1_out_valid", out_valid, 0);
        nxt(); wkup_data[1] = 32'hCAFE; wkup_data[0] = 32'hDEAD; smp();
        chk("wk_t2_out_valid", out_valid, 1);
        chk("wk_t2_data0", out_data[0], 32'hCAFE);
        chk("wk_t2_data1", out_data[1], 32'h22);
        nxt(); wkup_data[1] = 32'hBAD; smp();
        chk("wk_latched_data0", out_data[0], 32'hCAFE);
        nxt(); out_ready = 1'b1; smp();
        nxt(); smp();
        chk("wk_drain_count", count_o, 0);

        // CDB wakeup of a stored operand, duplicate tags on both channels
        nxt(); ins(32'h0, 32'h33, 6'd9, 6'd3, 2'b10, 64'h35); smp();
        nxt(); cdb_valid = 2'b11; cdb_tag[0] = 6'd9; cdb_data[0] = 32'h1234;
        cdb_tag[1] = 6'd9; cdb_data[1] = 32'h9999; smp();
        chk("cdb_t_out_valid", out_valid, 0);
        nxt(); out_ready = 1'b1; smp();
        chk("cdb_t1_out_valid", out_valid, 1);
        chk("cdb_t1_data0", out_data[0], 32'h1234);
        nxt(); smp();
        chk("cdb_drain_count", count_o, 0);

        // CDB capture on the insert cycle
        nxt(); ins(32'hFFFF, 32'h44, 6'd9, 6'd3, 2'b10, 64'h36);
        cdb_valid = 2'b10; cdb_tag[1] = 6'd9; cdb_data[1] = 32'h5678; smp();
        nxt(); out_ready = 1'b1; smp();
        chk("cdb_ins_out_valid", out_valid, 1);
        chk("cdb_ins_data0", out_data[0], 32'h5678);
        nxt(); smp();
        chk("cdb_ins_drain_count", count_o, 0);

        // selection order: A lands in slot 3 before B lands in slot 1
        nxt(); ins(0, 0, 6'd40, 6'd0, 2'b10, 64'd100); smp();
        nxt(); ins(0, 0, 6'd0, 6'd0, 2'b11, 64'd101); smp();
        nxt(); ins(0, 0, 6'd41, 6'd0, 2'b10, 64'd102); smp();
        nxt(); ins(0, 0, 6'd0, 6'd0, 2'b11, 64'd103); smp();
        nxt(); out_ready = 1'b1; smp();
        chk("sel_first_payload", out_payload, 101);
        nxt(); ins(0, 0, 6'd0, 6'd0, 2'b11, 64'hB); smp();
`ifdef IQ_AGE_SELECT_EN
        exp_first = 64'd103; exp_second = 64'hB;
`else
        exp_first = 64'hB; exp_second = 64'd103;
`endif
        nxt(); out_ready = 1'b1; smp();
        chk("sel_ab_first", out_payload, exp_first);
        nxt(); smp();
        chk("sel_ab_second", out_payload, exp_second);
        nxt(); flush = 1'b1;

        // flush with a wakeup in stage 1 and a simultaneous insert
        nxt(); ins(0, 0, 6'd50, 6'd0, 2'b10, 64'h50); smp();
        nxt(); wkup_valid = 2'b01; wkup_tag[0] = 6'd50; smp();
        nxt(); flush = 1'b1; ins(0, 0, 6'd0, 6'd0, 2'b11, 64'h51); smp();
        nxt(); wkup_data[0] = 32'hAAAA; smp();
        chk("flush_wk_count_a", count_o, 0);
        chk("flush_wk_out_valid_a", out_valid, 0);
        nxt(); smp();
        chk("flush_wk_count_b", count_o, 0);
        chk("flush_wk_out_valid_b", out_valid, 0);
        chk("flush_wk_in_ready", in_ready, 1);

        // random traffic against the reference model
        do_reset();
        m_clear();
        cyc = 0;
        seq_ctr = 0;
        for (int n = 0; n < 800; n++) begin
            @(posedge clk);
            #1;
            idle();
            flush = ($urandom_range(0, 99) < 2);
            in_valid = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 45);
            in_rdy = RC'($urandom);
            in_payload = {$urandom, $urandom};
            for (int r = 0; r < RC; r++) begin
                in_data[r] = $urandom;
                in_tag[r] = TW'($urandom_range(0, 7));
            end
            for (int c = 0; c < CC; c++) begin
                cdb_valid[c] = ($urandom_range(0, 99) < 25);
                cdb_tag[c] = TW'($urandom_range(0, 7));
                cdb_data[c] = $urandom;
            end
            for (int w = 0; w < WC; w++) begin
                wkup_valid[w] = ($urandom_range(0, 99) < 25);
                wkup_tag[w] = TW'($urandom_range(0, 7));
                wkup_data[w] = $urandom;
            end
            m_eval();
            @(negedge clk);
            chk("rnd_count", count_o, e_cnt);
            chk("rnd_in_ready", in_ready, (e_cnt < DEPTH));
            chk("rnd_out_valid", out_valid, e_ov);
            if (e_ov) begin
                chk("rnd_payload", out_payload, e_pl);
                for (int r = 0; r < RC; r++)
                    chk($sformatf("rnd_data%0d", r), out_data[r], e_data[r]);
            end
            m_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
